// File: rtl/sophon_img_loader_pkg.sv
// Shared types for the boot-image loader: FSM state encoding, abort codes
// and the byte width of each frame header field.
package sophon_img_loader_pkg;

  localparam int LDR_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_HDR_BASE,
    ST_HDR_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ALIGN   = 3'd1,
    ERR_LENGTH  = 3'd2,
    ERR_BUS     = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_CSUM    = 3'd5
  } loader_err_e;

endpackage

// File: rtl/sophon_img_loader_if.sv
// Byte-stream input and core ext-access bus seen by the boot-image loader.
interface sophon_stream_if;
  logic       s_valid_i;
  logic [7:0] s_data_i;
  logic       s_ready_o;

  modport master (output s_valid_i, output s_data_i, input  s_ready_o);
  modport slave  (input  s_valid_i, input  s_data_i, output s_ready_o);
endinterface

interface sophon_ext_if #(parameter int AW = 32);
  logic          ext_req_o;
  logic          ext_we_o;
  logic [AW-1:0] ext_addr_o;
  logic [AW-1:0] ext_wdata_o;
  logic          ext_ack_i;
  logic          ext_error_i;

  modport master (output ext_req_o, output ext_we_o, output ext_addr_o, output ext_wdata_o,
                  input  ext_ack_i, input  ext_error_i);
  modport slave  (input  ext_req_o, input  ext_we_o, input  ext_addr_o, input  ext_wdata_o,
                  output ext_ack_i, output ext_error_i);
endinterface

// File: rtl/sophon_img_loader_asm.sv
// Little-endian 4-byte word assembler with a running 8-bit frame checksum.
// Outputs are look-ahead values that include the byte accepted this cycle.
module sophon_img_loader_asm
  import sophon_img_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_clr,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_nxt,
  output logic        o_last,
  output logic [7:0]  o_csum_nxt
);
  localparam int CW = $clog2(LDR_HDR_BYTES);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_word;
  logic [7:0]    r_csum;

  // New bytes enter at the top so byte 0 ends up in bits 7:0 after four shifts.
  assign o_word_nxt = {i_byte, r_word[31:8]};
  assign o_last     = i_byte_vld && (r_cnt == CW'(LDR_HDR_BYTES - 1));
  assign o_csum_nxt = r_csum + i_byte;

  always_ff @(posedge clk_i) begin
    if (rst_i || i_clr) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_csum <= '0;
    end else if (i_byte_vld) begin
      r_cnt  <= r_cnt + 1'b1;
      r_word <= o_word_nxt;
      r_csum <= o_csum_nxt;
    end
  end

endmodule

// File: rtl/sophon_img_loader.sv
// Boot-image loader: parses a BASE/N/PAYLOAD/CSUM byte frame, writes each word
// over the core ext access port and releases core soft reset once verified.
//   state    | meaning
//   HDR_BASE | collecting 4-byte load base
//   HDR_LEN  | collecting 4-byte word count
//   DATA     | collecting next payload word
//   WRITE    | ext write outstanding, stream stalled
//   CSUM     | waiting for checksum byte
//   DONE     | image verified, core released
//   ERROR    | aborted, err_code_o valid
module sophon_img_loader
  import sophon_img_loader_pkg::*;
#(
  parameter int AW          = 32,
  parameter int MAX_WORDS   = 16384,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sophon_stream_if.slave s,
  sophon_ext_if.master   ext,
  input  logic           restart_i,
  output logic           rst_soft_no,
  output logic [AW-1:0]  bootaddr_o,
  output logic           done_o,
  output logic           err_o,
  output logic [2:0]     err_code_o
);
  localparam int WLW = $clog2(MAX_WORDS + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);

  loader_state_e r_state;
  loader_err_e   r_code;
  logic          r_s_ready, r_req, r_we, r_rst_soft_n, r_done, r_err;
  logic [AW-1:0] r_addr, r_wdata, r_bootaddr;
  logic [WLW-1:0] r_words_left;
  logic [TW-1:0] r_tmo;

  logic          w_acc, w_last, w_restart;
  logic [AW-1:0] w_word;
  logic [7:0]    w_csum;

  assign w_acc     = s.s_valid_i && r_s_ready;
  assign w_restart = restart_i && (r_state == ST_DONE || r_state == ST_ERROR);

  sophon_img_loader_asm u_asm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_clr      (w_restart),
    .i_byte_vld (w_acc),
    .i_byte     (s.s_data_i),
    .o_word_nxt (w_word),
    .o_last     (w_last),
    .o_csum_nxt (w_csum)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_HDR_BASE;
      r_code       <= ERR_NONE;
      r_s_ready    <= 1'b1;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_bootaddr   <= '0;
      r_rst_soft_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_words_left <= '0;
      r_tmo        <= '0;
    end else begin
      unique case (r_state)
        ST_HDR_BASE: if (w_last) begin
          if (w_word[1:0] != 2'b00) begin
            r_state   <= ST_ERROR;
            r_err     <= 1'b1;
            r_code    <= ERR_ALIGN;
            r_s_ready <= 1'b0;
          end else begin
            r_addr     <= w_word;
            r_bootaddr <= w_word;
            r_state    <= ST_HDR_LEN;
          end
        end
        ST_HDR_LEN: if (w_last) begin
          if (w_word > AW'(MAX_WORDS)) begin
            r_state   <= ST_ERROR;
            r_err     <= 1'b1;
            r_code    <= ERR_LENGTH;
            r_s_ready <= 1'b0;
          end else begin
            r_words_left <= w_word[WLW-1:0];
            r_state      <= (w_word == '0) ? ST_CSUM : ST_DATA;
          end
        end
        ST_DATA: if (w_last) begin
          r_wdata   <= w_word;
          r_req     <= 1'b1;
          r_we      <= 1'b1;
          r_tmo     <= '0;
          r_s_ready <= 1'b0;
          r_state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (ext.ext_ack_i) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (ext.ext_error_i) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
              r_code  <= ERR_BUS;
            end else begin
              r_addr       <= r_addr + AW'(4);
              r_words_left <= r_words_left - 1'b1;
              r_s_ready    <= 1'b1;
              r_state      <= (r_words_left == WLW'(1)) ? ST_CSUM : ST_DATA;
            end
          end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
            // Final cycle of the ack window: req has been high ACK_TIMEOUT cycles.
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_ERROR;
            r_err   <= 1'b1;
            r_code  <= ERR_TIMEOUT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_CSUM: if (w_acc) begin
          r_s_ready <= 1'b0;
          if (w_csum == 8'h00) begin
            r_state      <= ST_DONE;
            r_done       <= 1'b1;
            r_rst_soft_n <= 1'b1;
          end else begin
            r_state <= ST_ERROR;
            r_err   <= 1'b1;
            r_code  <= ERR_CSUM;
          end
        end
        ST_DONE, ST_ERROR: if (w_restart) begin
          r_state      <= ST_HDR_BASE;
          r_done       <= 1'b0;
          r_err        <= 1'b0;
          r_code       <= ERR_NONE;
          r_rst_soft_n <= 1'b0;
          r_s_ready    <= 1'b1;
        end
        default: r_state <= ST_HDR_BASE;
      endcase
    end
  end

  assign s.s_ready_o     = r_s_ready;
  assign ext.ext_req_o   = r_req;
  assign ext.ext_we_o    = r_we;
  assign ext.ext_addr_o  = r_addr;
  assign ext.ext_wdata_o = r_wdata;
  assign rst_soft_no     = r_rst_soft_n;
  assign bootaddr_o      = r_bootaddr;
  assign done_o          = r_done;
  assign err_o           = r_err;
  assign err_code_o      = r_code;

endmodule

// File: doc/sophon_img_loader.md
Name: sophon_img_loader

Overview:
- Synthesizable boot-image loader sitting directly upstream of SOPHON_TOP.
- Receives a framed byte stream (from a UART/debug bridge) and writes the image word by word into ITCM/DTCM through the core's external access port (SOPHON_EXT_ACCESS).
- Holds the core in soft reset until the image is fully written and checksum-verified, then releases it with the loaded boot address.
- Replaces the simulation-only backdoor preload on silicon and FPGA.

Parameters:
- AW, 32, address/data width of the ext access port.
- MAX_WORDS, 16384, largest accepted payload word count (64 KB).
- ACK_TIMEOUT, 1024, cycles to wait for ext_ack_i before aborting.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- s_valid_i  in  1  byte-stream valid.
- s_data_i  in  8  byte-stream data.
- s_ready_o  out  1  byte accepted when s_valid_i && s_ready_o.
- restart_i  in  1  one-cycle pulse; re-arms the loader from DONE/ERROR.
- ext_req_o  out  1  ext access request; drives SOPHON ext_req_i.
- ext_we_o  out  1  write enable; always 1 while ext_req_o is high.
- ext_addr_o  out  AW  byte address, word aligned.
- ext_wdata_o  out  AW  write data.
- ext_ack_i  in  1  access complete.
- ext_error_i  in  1  access error, qualified by ext_ack_i.
- rst_soft_no  out  1  core soft reset, active low; drives SOPHON rst_soft_ni.
- bootaddr_o  out  AW  boot address for the core (latched frame base).
- done_o  out  1  image loaded and verified.
- err_o  out  1  loader aborted.
- err_code_o  out  3  0 none, 1 align, 2 length, 3 bus error, 4 ack timeout, 5 checksum.

Behaviour:
- Frame format, all fields little-endian:
  - BASE: 4 bytes.
  - N: 4 bytes, word count.
  - PAYLOAD: N×4 bytes.
  - CSUM: 1 byte.
  - The 8-bit sum of every frame byte, including CSUM, must equal 0x00.
- Reset values:
  - s_ready_o=1, ext_req_o=0, ext_we_o=0, ext_addr_o=0, ext_wdata_o=0.
  - rst_soft_no=0, bootaddr_o=0, done_o=0, err_o=0, err_code_o=0.
  - State HDR_BASE; byte counter, word counter and checksum accumulator all 0.
- FSM states: HDR_BASE, HDR_LEN, DATA, WRITE, CSUM, DONE, ERROR.
- HDR_BASE:
  - Shift in 4 bytes.
  - On the 4th byte: if BASE[1:0]!=0 → ERROR code 1; else latch the address counter and bootaddr_o, go to HDR_LEN.
- HDR_LEN:
  - Shift in 4 bytes.
  - On the 4th byte: N>MAX_WORDS → ERROR code 2; N==0 → CSUM; else → DATA.
- DATA:
  - Assemble 4 bytes into the word register (byte 0 → bits 7:0).
  - On the 4th byte go to WRITE.
- WRITE:
  - s_ready_o=0.
  - Drive ext_req_o=1 and ext_we_o=1 with stable ext_addr_o/ext_wdata_o until ext_ack_i is sampled high; ack may arrive in the same cycle req rises.
  - On ack without error: ext_req_o=0 in the next cycle, address +4, words_left−1; go to CSUM if words_left reaches 0, else DATA.
  - On ack with ext_error_i → ERROR code 3.
  - No ack within ACK_TIMEOUT cycles of req rising → drop req, ERROR code 4.
  - At most one outstanding request.
- CSUM:
  - Accept 1 byte.
  - Accumulated sum==0 → DONE; else → ERROR code 5.
- Checksum accumulation: add every accepted byte, mod 256; the accumulator clears on entry to HDR_BASE.
- DONE:
  - done_o=1, rst_soft_no=1 in the cycle after entry; s_ready_o=0.
  - Bytes arriving in DONE are not consumed.
- ERROR:
  - err_o=1, err_code_o holds the code, rst_soft_no stays 0, s_ready_o=0.
- restart_i in DONE/ERROR:
  - Next cycle: HDR_BASE, done_o=0, err_o=0, err_code_o=0, rst_soft_no=0, s_ready_o=1.
  - restart_i is ignored in other states.
- rst_i mid-transfer: abort immediately to reset values; a pending ext_req_o drops the same edge, and any partial writes remain in TCM.
- Address wrap: the address increments modulo 2^AW, no check.
- Timeout counter: saturating, clears on each new req.

Decomposition:
- SOPHON_PKG additions:
  - loader_state_e enum.
  - loader_err_e 3-bit enum.
  - LDR_HDR_BYTES=4 constant.
- One sub-module, sophon_img_loader_asm: 4-byte little-endian assembler with byte counter and 8-bit checksum accumulator, shared by the BASE, LEN and DATA paths.
- FSM and ext handshake stay in the top.

Test Plan:
- Frame BASE=0x80000000, N=2, words 0x11223344 and 0xAABBCCDD, correct CSUM, ack one cycle after req → two writes to 0x80000000 and 0x80000004 with matching wdata; done_o=1, rst_soft_no=1, bootaddr_o=0x80000000.
- Same frame with CSUM+1 → both writes occur; err_o=1, err_code_o=5, rst_soft_no=0; then restart_i plus a valid frame → done_o=1.
- BASE=0x80000002 → no ext_req_o ever; err_code_o=1 after the 4th byte.
- N=MAX_WORDS+1 → err_code_o=2; N=0 with CSUM=two's complement of the header sum → done_o=1 with zero writes.
- ext_ack_i held low → ext_req_o high for exactly ACK_TIMEOUT cycles then drops; err_code_o=4. Separately, ack with ext_error_i on the 2nd word → err_code_o=3.
- Same-cycle ack, plus rst_i asserted during WRITE → next cycle ext_req_o=0, s_ready_o=1, state HDR_BASE, all outputs at reset values.
